// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit and its users.
// Op encodings, FSM states and a counter sizing helper.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    // Bits needed to count 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shared 2*WIDTH shift register and a WIDTH+1 adder/subtractor serve both ops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic               div_zero_q, div_zero_d;
    logic               done_q, done_d;

    logic               op_signed, op_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_x, add_y, add_s;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // Operand decode: signed ops work on magnitudes, sign fixed up in FIX.
    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        op_div    = (op == OP_DIV) || (op == OP_DIVU);
        a_neg     = op_signed && a[WIDTH-1];
        b_neg     = op_signed && b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    // Multiply adds the multiplicand to the upper half when the current
    // multiplier bit is set; divide subtracts the divisor from the shifted
    // partial remainder. A clear bit WIDTH on the difference means it fits.
    always_comb begin
        if (is_div_q) begin
            add_x = acc_q[2*WIDTH-1:WIDTH-1];
            add_y = ~{1'b0, opb_q};
        end else begin
            add_x = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
            add_y = acc_q[0] ? {1'b0, opb_q} : '0;
        end
        add_s = add_x + add_y + {{WIDTH{1'b0}}, is_div_q};
    end

    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (dz_q) quot_fix = '1;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    acc_d     = {{WIDTH{1'b0}}, a_mag};
                    opb_d     = b_mag;
                    is_div_d  = op_div;
                    dz_d      = op_div && (b == '0);
                    // A zero divisor keeps the all-ones quotient unsigned.
                    neg_res_d = (a_neg ^ b_neg) && !(op_div && (b == '0));
                    neg_rem_d = op_div && a_neg;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    if (add_s[WIDTH]) acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                    else              acc_d = {add_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {add_s, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                div_zero_d = dz_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level reference model plus directed literal vectors.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    logic         s_start;
    logic [1:0]   s_op;
    logic [7:0]   s_a, s_b;
    logic         s_busy, s_done, s_dz;
    logic [7:0]   s_hi, s_lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
        .hi_we(1'b0), .lo_we(1'b0), .wdata(8'h00),
        .busy(s_busy), .done(s_done), .div_zero(s_dz), .hi(s_hi), .lo(s_lo)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Architectural result from plain integer arithmetic.
    function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
        longint sx, sy, q, r;
        longint unsigned ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        z  = 1'b0;
        h  = '0;
        l  = '0;
        case (o)
            OP_MULT:  begin q = sx * sy; {h, l} = q; end
            OP_MULTU: begin p = ux * uy; {h, l} = p; end
            default: begin
                if (y == '0) begin
                    z = 1'b1; l = '1; h = x;
                end else if (o == OP_DIV) begin
                    q = sx / sy; r = sx % sy;
                    l = q[W-1:0]; h = r[W-1:0];
                end else begin
                    l = x / y; h = x % y;
                end
            end
        endcase
    endfunction

    // Reference: idle when no cycles remain; an accepted op completes W+1 edges later.
    int           m_cnt = 0;
    logic         m_done, m_dz, r_dz;
    logic [W-1:0] m_hi, m_lo, r_hi, r_lo;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0;
        end else begin
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
                if (start) begin
                    ref_op(op, a, b, r_hi, r_lo, r_dz);
                    m_cnt = W + 1;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hi = r_hi; m_lo = r_lo; m_dz = r_dz; m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_cnt != 0);
            check("done", done, m_done);
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("div_zero", div_zero, m_dz);
        end
    end

    typedef struct {
        logic [1:0]   o;
        logic [W-1:0] x, y, eh, el;
        logic         ez;
    } vec_t;

    vec_t vt[11];

    // Issues one op and returns at the negedge where done is seen.
    task automatic do_op(input vec_t v, input bit inj, input bit now, output int lat, output int bc);
        if (!now) @(negedge clk);
        start = 1'b1; op = v.o; a = v.x; b = v.y;
        @(negedge clk);
        start = 1'b0;
        lat = 0; bc = 0;
        while (!done && lat < 100) begin
            if (busy) bc++;
            if (inj && lat == 5) begin
                start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1;
                hi_we = 1'b1; wdata = 32'hAAAA5555;
            end else begin
                start = 1'b0; hi_we = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                          output int lat, output int bc);
        @(negedge clk);
        s_start = 1'b1; s_op = o; s_a = x; s_b = y;
        @(negedge clk);
        s_start = 1'b0;
        lat = 0; bc = 0;
        while (!s_done && lat < 100) begin
            if (s_busy) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bc, dcnt;
        vt[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vt[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vt[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vt[3]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        vt[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vt[5]  = '{OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
        vt[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vt[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vt[8]  = '{OP_DIV,   32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0};
        vt[9]  = '{OP_DIV,   32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0};
        vt[10] = '{OP_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        s_start = 1'b0; s_op = '0; s_a = '0; s_b = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_zero, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Vector 1 also tries a second start and MTHI mid-flight; vector 3 starts in the done cycle.
        for (int i = 0; i < 11; i++) begin
            do_op(vt[i], i == 1, i == 3, lat, bc);
            check($sformatf("v%0d_latency", i), lat, 33);
            check($sformatf("v%0d_busy_cycles", i), bc, 33);
            check($sformatf("v%0d_hi", i), hi, vt[i].eh);
            check($sformatf("v%0d_lo", i), lo, vt[i].el);
            check($sformatf("v%0d_dz", i), div_zero, vt[i].ez);
        end

        // MTLO in the done cycle lands on the next edge.
        lo_we = 1'b1; wdata = 32'h13572468;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_done_cycle", lo, 32'h13572468);

        // MTHI together with an accepted start lands, then the result overwrites it.
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h00005A5A;
        start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("mthi_with_start", hi, 32'h00005A5A);
        lat = 0;
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        check("mthi_start_lat", lat, 33);
        check("mthi_start_hi", hi, 0);
        check("mthi_start_lo", lo, 12);

        // Reset at cycle 10 of a MULT aborts it.
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'h00001234; b = 32'h00005678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_busy", busy, 0);
        dcnt = 0;
        repeat (45) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort_no_done", dcnt, 0);

        // Narrow instance.
        do_op8(OP_MULT, 8'h80, 8'h80, lat, bc);
        check("w8_mult_lat", lat, 9);
        check("w8_mult_busy", bc, 9);
        check("w8_mult_hi", s_hi, 8'h40);
        check("w8_mult_lo", s_lo, 8'h00);
        do_op8(OP_DIVU, 8'hFF, 8'h10, lat, bc);
        check("w8_divu_lat", lat, 9);
        check("w8_divu_hi", s_hi, 8'h0F);
        check("w8_divu_lo", s_lo, 8'h0F);
        check("w8_divu_dz", s_dz, 0);
        do_op8(OP_DIV, 8'h80, 8'hFF, lat, bc);
        check("w8_div_ovf_hi", s_hi, 8'h00);
        check("w8_div_ovf_lo", s_lo, 8'h80);
        do_op8(OP_DIV, 8'hF9, 8'h00, lat, bc);
        check("w8_divz_lat", lat, 9);
        check("w8_divz_hi", s_hi, 8'hF9);
        check("w8_divz_lo", s_lo, 8'hFF);
        check("w8_divz_dz", s_dz, 1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
